// File: rtl/core_mem_responder.sv
// Memory responder for a core: randomised grant latency from an 8-bit LFSR,
// byte-strobed writes into a word store with a read-only low region, and a sticky protocol flag.
module core_mem_responder #(
  parameter int         MEM_DEPTH = 256,
  parameter int         ROM_WORDS = 64,
  parameter int         MAX_STALL = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [7:0]  mem_strb,
  input  logic [63:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_err,
  output logic [63:0] mem_rdata,
  output logic        proto_err
);

  localparam int         AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [7:0] STALL_MASK = 8'(MAX_STALL);
  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] WAIT       = 1'b1;

  logic [0:0]  state_reg;
  logic [7:0]  stall_cnt_reg;
  logic [7:0]  lfsr_reg;
  logic        lfsr_fb;
  logic [63:0] cap_addr_reg;
  logic        cap_wen_reg;
  logic [7:0]  cap_strb_reg;
  logic [63:0] cap_wdata_reg;
  logic        err_reg;
  logic        rd_sel_reg;
  logic        proto_err_reg;
  logic [63:0] mem_q_reg;
  logic [63:0] mem [MEM_DEPTH];

  logic [60:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          req_bad;
  logic          handshake;
  logic          fields_changed;
  logic [7:0]    byte_we;

  assign word_idx = mem_addr[63:3];
  assign mem_idx  = mem_addr[3 +: AW];
  assign req_bad  = (mem_addr[2:0] != 3'd0)
                 || (word_idx >= 61'(MEM_DEPTH))
                 || (mem_wen && (word_idx < 61'(ROM_WORDS)));

  // Grant is suppressed under reset so a pending request is abandoned cleanly.
  assign mem_gnt   = !g_reset && (state_reg == WAIT) && mem_req && (stall_cnt_reg == 8'd0);
  assign handshake = mem_gnt;

  assign fields_changed = (mem_addr != cap_addr_reg) || (mem_wen != cap_wen_reg)
                       || (mem_strb != cap_strb_reg) || (mem_wdata != cap_wdata_reg);

  // Taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_we
      assign byte_we[gi] = handshake && mem_wen && !req_bad && mem_strb[gi];
    end
  endgenerate

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_reg     <= IDLE;
      stall_cnt_reg <= 8'd0;
      lfsr_reg      <= LFSR_SEED;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_req) begin
            state_reg     <= WAIT;
            stall_cnt_reg <= lfsr_reg & STALL_MASK;
            lfsr_reg      <= {lfsr_reg[6:0], lfsr_fb};
          end
        end
        WAIT: begin
          if (stall_cnt_reg != 8'd0) begin
            stall_cnt_reg <= stall_cnt_reg - 8'd1;
          end
          if (handshake) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (state_reg == IDLE && mem_req) begin
      cap_addr_reg  <= mem_addr;
      cap_wen_reg   <= mem_wen;
      cap_strb_reg  <= mem_strb;
      cap_wdata_reg <= mem_wdata;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      proto_err_reg <= 1'b0;
    end else if (state_reg == WAIT && (!mem_req || fields_changed)) begin
      proto_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      err_reg    <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else if (handshake) begin
      err_reg    <= req_bad;
      rd_sel_reg <= !req_bad && !mem_wen;
    end
  end

  // Store and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge g_clk) begin
    for (int b = 0; b < 8; b++) begin
      if (byte_we[b]) begin
        mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (handshake) begin
      mem_q_reg <= mem[mem_idx];
    end
  end

  assign mem_err   = err_reg;
  assign mem_rdata = rd_sel_reg ? mem_q_reg : 64'd0;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: the driver queues expected responses,
// a monitor pops and compares one cycle after each handshake.
module tb_core_mem_responder;

  logic        clk;
  logic        g_reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;
  logic        proto_err;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   hs_prev = 0;

  core_mem_responder dut (
    .g_clk     (clk),
    .g_reset   (g_reset),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_err   (mem_err),
    .mem_rdata (mem_rdata),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drop_req();
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_strb  = 8'h00;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
  endtask

  // Issue one request, wait for the grant, queue the expected response.
  // exp_lat: cycles from request to grant, or -1 to skip that comparison.
  task automatic do_req(input string name, input logic [63:0] addr, input logic wen,
                        input logic [7:0] strb, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_rdata, input int exp_lat);
    int lat;
    bit got;
    exp_t e;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_addr = addr; mem_wen = wen; mem_strb = strb; mem_wdata = wdata;
    got = 0;
    lat = 0;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(negedge clk);
      if (mem_gnt) begin
        got = 1;
        lat = c - 1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_grant: no grant within 300 cycles, expected one", name);
    end else begin
      e.err = exp_err; e.rdata = exp_rdata; e.name = name;
      sb_q.push_back(e);
      if (exp_lat >= 0) chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    end
    @(posedge clk); #1;
    drop_req();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    g_reset = 1'b1;
    drop_req();
    repeat (2) @(posedge clk);
    #1 g_reset = 1'b0;
  endtask

  // Monitor: outputs of a handshake are compared on the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: err=%0b rdata=%h, expected no handshake", mem_err, mem_rdata);
        end else begin
          e = sb_q.pop_front();
          $display("txn %-14s err=%0b rdata=%h (expect err=%0b rdata=%h)",
                   e.name, mem_err, mem_rdata, e.err, e.rdata);
          chk({e.name, "_err"}, 64'(mem_err), 64'(e.err));
          chk({e.name, "_rdata"}, mem_rdata, e.rdata);
        end
      end
      hs_prev = mem_req && mem_gnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    dut.mem[2] = 64'hDEADBEEF01234567;
    g_reset = 1'b1;
    drop_req();
    mem_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 64'(mem_gnt), 64'd0);
    chk("reset_err", 64'(mem_err), 64'd0);
    chk("reset_rdata", mem_rdata, 64'd0);
    chk("reset_proto", 64'(proto_err), 64'd0);
    @(posedge clk); #1;
    drop_req();
    g_reset = 1'b0;

    // LFSR A5,4A,95,2A,54,A9,53 masked by 3 gives stalls 1,2,1,2,0,1,3.
    do_req("wr_w64",    64'h200, 1'b1, 8'hFF, 64'h1122334455667788, 1'b0, 64'd0, 2);
    do_req("rd_w64",    64'h200, 1'b0, 8'h00, 64'd0, 1'b0, 64'h1122334455667788, 3);
    do_req("clr_w65",   64'h208, 1'b1, 8'hFF, 64'd0, 1'b0, 64'd0, 2);
    do_req("wr_w65_lo", 64'h208, 1'b1, 8'h0F, 64'hFFFFFFFF_AABBCCDD, 1'b0, 64'd0, 3);
    do_req("rd_w65",    64'h208, 1'b0, 8'h00, 64'd0, 1'b0, 64'h00000000_AABBCCDD, 1);
    do_req("wr_rom",    64'h10,  1'b1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0, 2);
    do_req("rd_misal",  64'h804, 1'b0, 8'h00, 64'd0, 1'b1, 64'd0, 4);
    do_req("rd_oob",    64'h800, 1'b0, 8'h00, 64'd0, 1'b1, 64'd0, -1);
    do_req("rd_w2",     64'h10,  1'b0, 8'h00, 64'd0, 1'b0, 64'hDEADBEEF01234567, -1);
    do_req("wr_rom_top", 64'h1F8, 1'b1, 8'hFF, 64'h5555, 1'b1, 64'd0, -1);
    do_req("rd_hi_bit", 64'h8000000000000200, 1'b0, 8'h00, 64'd0, 1'b1, 64'd0, -1);
    do_req("wr_nostrb", 64'h200, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'd0, -1);
    do_req("rd_w64_b",  64'h200, 1'b0, 8'h00, 64'd0, 1'b0, 64'h1122334455667788, -1);
    repeat (3) @(negedge clk);
    chk("hold_rdata", mem_rdata, 64'h1122334455667788);
    do_req("wr_w255",   64'h7F8, 1'b1, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'd0, -1);
    do_req("wr_w255_m", 64'h7F8, 1'b1, 8'h81, 64'hFF000000000000EE, 1'b0, 64'd0, -1);
    do_req("rd_w255",   64'h7F8, 1'b0, 8'h00, 64'd0, 1'b0, 64'hFF23456789ABCDEE, -1);
    @(negedge clk);
    chk("proto_clean", 64'(proto_err), 64'd0);

    // Reset while a write waits: it must be dropped and the LFSR reseeded.
    pulse_reset();
    @(posedge clk); #1;
    mem_req = 1'b1; mem_addr = 64'h200; mem_wen = 1'b1; mem_strb = 8'hFF; mem_wdata = 64'hBAD0BAD0BAD0BAD0;
    repeat (2) @(negedge clk);
    chk("wait_stall_gnt", 64'(mem_gnt), 64'd0);
    @(posedge clk); #1;
    g_reset = 1'b1;
    @(negedge clk);
    chk("reset_in_wait_gnt", 64'(mem_gnt), 64'd0);
    @(posedge clk); #1;
    g_reset = 1'b0;
    drop_req();
    do_req("rd_after_rst", 64'h200, 1'b0, 8'h00, 64'd0, 1'b0, 64'h1122334455667788, 2);
    do_req("rd_second",    64'h7F8, 1'b0, 8'h00, 64'd0, 1'b0, 64'hFF23456789ABCDEE, 3);

    // Request dropped while waiting with stall count 2.
    pulse_reset();
    do_req("rd_pre_drop", 64'h208, 1'b0, 8'h00, 64'd0, 1'b0, 64'h00000000_AABBCCDD, 2);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_addr = 64'h200;
    @(posedge clk); #1;
    drop_req();
    @(negedge clk);
    chk("proto_before", 64'(proto_err), 64'd0);
    @(negedge clk);
    chk("proto_set", 64'(proto_err), 64'd1);
    repeat (3) @(negedge clk);
    chk("proto_sticky", 64'(proto_err), 64'd1);
    pulse_reset();
    @(negedge clk);
    chk("proto_cleared", 64'(proto_err), 64'd0);

    // Address changed mid-wait: flag raised, grant follows the live address.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_addr = 64'h200;
    @(posedge clk); #1;
    mem_addr = 64'h208;
    @(negedge clk);
    chk("chg_no_gnt", 64'(mem_gnt), 64'd0);
    @(negedge clk);
    chk("chg_proto", 64'(proto_err), 64'd1);
    chk("chg_gnt", 64'(mem_gnt), 64'd1);
    if (mem_gnt) begin
      e.err = 1'b0; e.rdata = 64'h00000000_AABBCCDD; e.name = "rd_live_addr";
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    drop_req();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
